alu_cmd_issuer: RTL and testbench

Command issue stage that sits directly upstream of the ALU. It accepts operation requests over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It then drives the ALU input bus (CE, MODE, CMD, OPA, OPB, CIN, INP_VALID) with one command per issue slot, inserting idle gaps after multiply commands so the ALU's multi-cycle multiply is never overrun.

---
 rtl/alu_cmd_issuer.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
//
// Command issue stage placed directly in front of the ALU. Requests arrive on
// a valid/ready handshake, are buffered in a DEPTH-entry FIFO, and are then
// presented to the ALU input bus one per issue slot. After every multiply the
// stage leaves MUL_GAP idle cycles so the ALU's multi-cycle multiplier is never
// overrun.
//
// Optional feature macro: ALU_ISSUE_CMD_CHECK_EN
//   defined   : illegal commands (arith CMD > 10, logic CMD > 13) are
//               handshaked but discarded; drop_pulse flags each discard.
//   undefined : every accepted request is queued and issued; drop_pulse = 0.
//
// Ports
//   CLK, RESET            clock (posedge) / asynchronous active-low reset
//   in_valid, in_ready    request handshake
//   in_mode, in_cmd       request mode (1 = arithmetic) and opcode
//   in_opa, in_opb        request operands
//   in_cin, in_inp_valid  request carry-in and operand-valid bits
//   hold                  downstream stall, blocks new issues
//   CE                    ALU clock enable, high only in an issue cycle
//   MODE, CMD, OPA, OPB,
//   CIN, INP_VALID        registered ALU input bus
//   fifo_level            FIFO occupancy
//   issued_cnt            number of commands issued (wraps)
//   drop_pulse            one-cycle pulse per discarded illegal request
module alu_cmd_issuer #(
    parameter int DATA_WIDTH = 8,
    parameter int CMD_WIDTH  = 4,
    parameter int DEPTH      = 8,
    parameter int MUL_GAP    = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic [CMD_WIDTH-1:0]    in_cmd,
    input  logic [DATA_WIDTH-1:0]   in_opa,
    input  logic [DATA_WIDTH-1:0]   in_opb,
    input  logic                    in_cin,
    input  logic [1:0]              in_inp_valid,
    input  logic                    hold,
    output logic                    CE,
    output logic                    MODE,
    output logic [CMD_WIDTH-1:0]    CMD,
    output logic [DATA_WIDTH-1:0]   OPA,
    output logic [DATA_WIDTH-1:0]   OPB,
    output logic                    CIN,
    output logic [1:0]              INP_VALID,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [15:0]             issued_cnt,
    output logic                    drop_pulse
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int GAP_W = (MUL_GAP > 0) ? $clog2(MUL_GAP + 1) : 1;

    typedef struct packed {
        logic                  mode;
        logic [CMD_WIDTH-1:0]  cmd;
        logic [DATA_WIDTH-1:0] opa;
        logic [DATA_WIDTH-1:0] opb;
        logic                  cin;
        logic [1:0]            inpValid;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_t;

    entry_t                fifoMem_q [DEPTH];
    logic [PTR_W-1:0]      wrPtr_q;
    logic [PTR_W-1:0]      rdPtr_q;
    logic [LVL_W-1:0]      fifoLevel_q;

    state_t                state_q;
    state_t                state_d;
    logic [GAP_W-1:0]      gapCnt_q;
    logic [GAP_W-1:0]      gapCnt_d;

    logic                  aluCe_q;
    logic                  aluMode_q;
    logic [CMD_WIDTH-1:0]  aluCmd_q;
    logic [DATA_WIDTH-1:0] aluOpa_q;
    logic [DATA_WIDTH-1:0] aluOpb_q;
    logic                  aluCin_q;
    logic [1:0]            aluInpValid_q;
    logic [15:0]           issuedCnt_q;

    entry_t                reqEntry;
    entry_t                headEntry;
    logic                  headIsMul;
    logic                  reqLegal;
    logic                  push;
    logic                  issue;
    logic                  canIssue;

    // in_ready depends only on the registered level, so a pop in the same
    // cycle never lets a full FIFO accept.
    assign in_ready  = (fifoLevel_q < LVL_W'(DEPTH));
    assign push      = in_valid && in_ready && reqLegal;
    assign canIssue  = (fifoLevel_q != '0) && !hold;

    assign reqEntry  = '{mode: in_mode, cmd: in_cmd, opa: in_opa, opb: in_opb,
                         cin: in_cin, inpValid: in_inp_valid};
    assign headEntry = fifoMem_q[rdPtr_q];
    assign headIsMul = headEntry.mode &&
                       ((headEntry.cmd == CMD_WIDTH'(9)) || (headEntry.cmd == CMD_WIDTH'(10)));

`ifdef ALU_ISSUE_CMD_CHECK_EN
    logic reqIllegal;
    logic dropPulse_q;

    assign reqIllegal = in_mode ? (in_cmd > CMD_WIDTH'(10)) : (in_cmd > CMD_WIDTH'(13));
    assign reqLegal   = !reqIllegal;
    assign drop_pulse = dropPulse_q;

    // An illegal request still completes its handshake; it is simply not
    // written, and the drop is reported one cycle after acceptance.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            dropPulse_q <= 1'b0;
        end else begin
            dropPulse_q <= in_valid && in_ready && reqIllegal;
        end
    end
`else
    assign reqLegal   = 1'b1;
    assign drop_pulse = 1'b0;
`endif

    // FIFO storage needs no reset: flushing the pointers and level is enough
    // to make every stale entry unreachable.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= reqEntry;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoLevel_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (issue) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            case ({push, issue})
                2'b10:   fifoLevel_q <= fifoLevel_q + LVL_W'(1);
                2'b01:   fifoLevel_q <= fifoLevel_q - LVL_W'(1);
                default: fifoLevel_q <= fifoLevel_q;
            endcase
        end
    end

    // Issue sequencing. The gap counter is loaded at the issue edge itself,
    // so the MUL_GAP countdown edges directly follow the multiply and the
    // next command can go out exactly MUL_GAP+1 edges later. The countdown
    // ignores hold.
    always_comb begin
        state_d  = state_q;
        gapCnt_d = gapCnt_q;
        issue    = 1'b0;
        case (state_q)
            IDLE: begin
                if (canIssue) begin
                    issue = 1'b1;
                end
            end
            ISSUE, GAP: begin
                if (gapCnt_q != '0) begin
                    state_d  = GAP;
                    gapCnt_d = gapCnt_q - GAP_W'(1);
                end else if (canIssue) begin
                    issue = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (issue) begin
            state_d  = ISSUE;
            gapCnt_d = headIsMul ? GAP_W'(MUL_GAP) : '0;
        end
    end

    // State register for the issue sequencer.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            gapCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            gapCnt_q <= gapCnt_d;
        end
    end

    // ALU-side output registers. Outside an issue cycle CE and INP_VALID drop
    // to zero while the data fields keep their last values, so the ALU bus
    // does not toggle needlessly.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            aluCe_q       <= 1'b0;
            aluMode_q     <= 1'b0;
            aluCmd_q      <= '0;
            aluOpa_q      <= '0;
            aluOpb_q      <= '0;
            aluCin_q      <= 1'b0;
            aluInpValid_q <= 2'b00;
            issuedCnt_q   <= '0;
        end else begin
            aluCe_q <= issue;
            if (issue) begin
                aluMode_q     <= headEntry.mode;
                aluCmd_q      <= headEntry.cmd;
                aluOpa_q      <= headEntry.opa;
                aluOpb_q      <= headEntry.opb;
                aluCin_q      <= headEntry.cin;
                aluInpValid_q <= headEntry.inpValid;
                issuedCnt_q   <= issuedCnt_q + 16'd1;
            end else begin
                aluInpValid_q <= 2'b00;
            end
        end
    end

    assign CE         = aluCe_q;
    assign MODE       = aluMode_q;
    assign CMD        = aluCmd_q;
    assign OPA        = aluOpa_q;
    assign OPB        = aluOpb_q;
    assign CIN        = aluCin_q;
    assign INP_VALID  = aluInpValid_q;
    assign fifo_level = fifoLevel_q;
    assign issued_cnt = issuedCnt_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Testbench for alu_cmd_issuer: directed scenarios with hand-computed
// expectations plus a long randomized run, all checked every cycle against a
// queue-based model that tracks issue slots by cycle timestamps.
module tb_alu_cmd_issuer;

    localparam int DW      = 8;
    localparam int CW      = 4;
    localparam int DEPTH   = 8;
    localparam int MUL_GAP = 2;
    localparam int LW      = $clog2(DEPTH) + 1;

`ifdef ALU_ISSUE_CMD_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef struct packed {
        logic          mode;
        logic [CW-1:0] cmd;
        logic [DW-1:0] opa;
        logic [DW-1:0] opb;
        logic          cin;
        logic [1:0]    iv;
    } entry_t;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_mode = 1'b0;
    logic [CW-1:0] in_cmd = '0;
    logic [DW-1:0] in_opa = '0;
    logic [DW-1:0] in_opb = '0;
    logic          in_cin = 1'b0;
    logic [1:0]    in_inp_valid = 2'b00;
    logic          hold = 1'b0;

    logic          in_ready;
    logic          CE;
    logic          MODE;
    logic [CW-1:0] CMD;
    logic [DW-1:0] OPA;
    logic [DW-1:0] OPB;
    logic          CIN;
    logic [1:0]    INP_VALID;
    logic [LW-1:0] fifo_level;
    logic [15:0]   issued_cnt;
    logic          drop_pulse;

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    entry_t      q[$];
    int          cycle = 0;
    int          nextAllowed = 0;
    logic        expCe = 1'b0;
    entry_t      expOut = '0;
    logic [15:0] expCnt = 16'd0;
    logic        expDrop = 1'b0;

    alu_cmd_issuer #(
        .DATA_WIDTH (DW),
        .CMD_WIDTH  (CW),
        .DEPTH      (DEPTH),
        .MUL_GAP    (MUL_GAP)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_cmd       (in_cmd),
        .in_opa       (in_opa),
        .in_opb       (in_opb),
        .in_cin       (in_cin),
        .in_inp_valid (in_inp_valid),
        .hold         (hold),
        .CE           (CE),
        .MODE         (MODE),
        .CMD          (CMD),
        .OPA          (OPA),
        .OPB          (OPB),
        .CIN          (CIN),
        .INP_VALID    (INP_VALID),
        .fifo_level   (fifo_level),
        .issued_cnt   (issued_cnt),
        .drop_pulse   (drop_pulse)
    );

    // Free-running clock, 10 time-unit period.
    always #5 CLK = ~CLK;

    function automatic bit isMul(entry_t e);
        return e.mode && ((e.cmd == 4'd9) || (e.cmd == 4'd10));
    endfunction

    function automatic bit isIllegal(logic m, logic [CW-1:0] c);
        return m ? (c > 4'd10) : (c > 4'd13);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #2;
    endtask

    task automatic applyStimulus(input logic v, input logic m, input logic [CW-1:0] c,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic ci, input logic [1:0] iv, input logic h);
        in_valid     = v;
        in_mode      = m;
        in_cmd       = c;
        in_opa       = a;
        in_opb       = b;
        in_cin       = ci;
        in_inp_valid = iv;
        hold         = h;
    endtask

    task automatic applyIdle(input logic h);
        in_valid = 1'b0;
        hold     = h;
    endtask

    // Model: the queue holds accepted legal requests; an issue may happen at
    // edge n when the queue was non-empty before the edge, hold is low and n
    // has reached the earliest slot allowed by the last multiply.
    always @(posedge CLK or negedge RESET) begin : modelStep
        bit     doIssue;
        bit     accept;
        bit     illegal;
        entry_t req;
        if (!RESET) begin
            q.delete();
            cycle       = 0;
            nextAllowed = 0;
            expCe       = 1'b0;
            expOut      = '0;
            expCnt      = 16'd0;
            expDrop     = 1'b0;
        end else begin
            accept   = in_valid && (q.size() < DEPTH);
            req.mode = in_mode;
            req.cmd  = in_cmd;
            req.opa  = in_opa;
            req.opb  = in_opb;
            req.cin  = in_cin;
            req.iv   = in_inp_valid;
            illegal  = CHECK_EN && isIllegal(in_mode, in_cmd);
            doIssue  = (q.size() > 0) && !hold && (cycle >= nextAllowed);
            if (doIssue) begin
                expOut      = q.pop_front();
                expCe       = 1'b1;
                expCnt      = expCnt + 16'd1;
                nextAllowed = isMul(expOut) ? cycle + 1 + MUL_GAP : cycle + 1;
            end else begin
                expCe     = 1'b0;
                expOut.iv = 2'b00;
            end
            if (accept && !illegal) begin
                q.push_back(req);
            end
            expDrop = accept && illegal;
            cycle++;
        end
    end

    // Every cycle, on the falling edge, the whole output bus is compared
    // against the model.
    always @(negedge CLK) begin
        checkOutput("ce",         32'(CE),         32'(expCe));
        checkOutput("inp_valid",  32'(INP_VALID),  32'(expOut.iv));
        checkOutput("mode",       32'(MODE),       32'(expOut.mode));
        checkOutput("cmd",        32'(CMD),        32'(expOut.cmd));
        checkOutput("opa",        32'(OPA),        32'(expOut.opa));
        checkOutput("opb",        32'(OPB),        32'(expOut.opb));
        checkOutput("cin",        32'(CIN),        32'(expOut.cin));
        checkOutput("issued_cnt", 32'(issued_cnt), 32'(expCnt));
        checkOutput("fifo_level", 32'(fifo_level), 32'(q.size()));
        checkOutput("in_ready",   32'(in_ready),   32'(q.size() < DEPTH));
        checkOutput("drop_pulse", 32'(drop_pulse), 32'(expDrop));
    end

    initial begin : stimulus
        logic [3:0] pat;
        #1 RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        checkOutput("rst_ce",       32'(CE),         32'd0);
        checkOutput("rst_level",    32'(fifo_level), 32'd0);
        checkOutput("rst_issued",   32'(issued_cnt), 32'd0);
        RESET = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready),   32'd1);

        // Single ADD: accepted at edge k, on the bus after edge k+1.
        applyStimulus(1'b1, 1'b1, 4'd0, 8'h05, 8'h03, 1'b0, 2'b11, 1'b0);
        nextCycle();
        applyIdle(1'b0);
        checkOutput("add_level", 32'(fifo_level), 32'd1);
        checkOutput("add_ce_early", 32'(CE), 32'd0);
        nextCycle();
        checkOutput("add_ce",     32'(CE),         32'd1);
        checkOutput("add_opa",    32'(OPA),        32'h05);
        checkOutput("add_opb",    32'(OPB),        32'h03);
        checkOutput("add_iv",     32'(INP_VALID),  32'h3);
        checkOutput("add_issued", 32'(issued_cnt), 32'd1);
        nextCycle();
        checkOutput("add_ce_off", 32'(CE),        32'd0);
        checkOutput("add_iv_off", 32'(INP_VALID), 32'd0);
        checkOutput("add_opa_kept", 32'(OPA),     32'h05);

        // Fill to full under hold, try a ninth push, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b1, 4'd1, 8'(16 + i), 8'h20, 1'b1, 2'b11, 1'b1);
            nextCycle();
        end
        checkOutput("full_level", 32'(fifo_level), 32'd8);
        checkOutput("full_ready", 32'(in_ready),   32'd0);
        applyStimulus(1'b1, 1'b0, 4'd2, 8'hEE, 8'hEE, 1'b0, 2'b01, 1'b1);
        nextCycle();
        checkOutput("full_level_9th", 32'(fifo_level), 32'd8);
        applyIdle(1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            nextCycle();
            checkOutput("drain_ce",  32'(CE),  32'd1);
            checkOutput("drain_opa", 32'(OPA), 32'(16 + i));
        end
        nextCycle();
        checkOutput("drain_done_ce",    32'(CE),         32'd0);
        checkOutput("drain_done_level", 32'(fifo_level), 32'd0);

        // Multiply followed by ADD: CE pattern 1,0,0,1.
        applyStimulus(1'b1, 1'b1, 4'd9, 8'h03, 8'h04, 1'b0, 2'b11, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 4'd0, 8'h07, 8'h01, 1'b0, 2'b11, 1'b1);
        nextCycle();
        applyIdle(1'b0);
        pat = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkOutput("mul_gap_ce", 32'(CE), 32'(pat[3 - i]));
        end
        checkOutput("mul_gap_opa", 32'(OPA), 32'h07);

        // Hold for three cycles after the second issue of a four-deep burst.
        applyIdle(1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd3, 8'(64 + i), 8'h55, 1'b0, 2'b10, 1'b1);
            nextCycle();
        end
        applyIdle(1'b0);
        nextCycle();
        checkOutput("hold_ce1",  32'(CE),  32'd1);
        checkOutput("hold_opa1", 32'(OPA), 32'h40);
        nextCycle();
        checkOutput("hold_ce2",  32'(CE),  32'd1);
        checkOutput("hold_opa2", 32'(OPA), 32'h41);
        applyIdle(1'b1);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput("hold_ce_stall", 32'(CE),  32'd0);
            checkOutput("hold_opa_kept", 32'(OPA), 32'h41);
        end
        applyIdle(1'b0);
        nextCycle();
        checkOutput("hold_opa3", 32'(OPA), 32'h42);
        nextCycle();
        checkOutput("hold_opa4", 32'(OPA), 32'h43);
        nextCycle();
        checkOutput("hold_ce_end", 32'(CE), 32'd0);

        // Illegal logical command 14.
        applyStimulus(1'b1, 1'b0, 4'd14, 8'h11, 8'h22, 1'b0, 2'b11, 1'b0);
        nextCycle();
        applyIdle(1'b0);
`ifdef ALU_ISSUE_CMD_CHECK_EN
        checkOutput("illegal_drop",  32'(drop_pulse), 32'd1);
        checkOutput("illegal_level", 32'(fifo_level), 32'd0);
        nextCycle();
        checkOutput("illegal_drop_off", 32'(drop_pulse), 32'd0);
        checkOutput("illegal_no_ce",    32'(CE),         32'd0);
`else
        checkOutput("illegal_level", 32'(fifo_level), 32'd1);
        nextCycle();
        checkOutput("illegal_ce",  32'(CE),  32'd1);
        checkOutput("illegal_cmd", 32'(CMD), 32'd14);
`endif
        nextCycle();

        // Reset in the middle of a multiply gap with three entries queued.
        applyStimulus(1'b1, 1'b1, 4'd10, 8'h90, 8'h91, 1'b1, 2'b11, 1'b1);
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 4'd1, 8'(160 + i), 8'h01, 1'b0, 2'b11, 1'b1);
            nextCycle();
        end
        applyIdle(1'b0);
        nextCycle();
        checkOutput("rgap_ce_mul", 32'(CE), 32'd1);
        nextCycle();
        checkOutput("rgap_in_gap", 32'(CE), 32'd0);
        RESET = 1'b0;
        #1;
        checkOutput("rgap_level",  32'(fifo_level), 32'd0);
        checkOutput("rgap_issued", 32'(issued_cnt), 32'd0);
        checkOutput("rgap_ce",     32'(CE),         32'd0);
        nextCycle();
        RESET = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            checkOutput("rgap_no_stale", 32'(CE), 32'd0);
        end

        // Randomized traffic with varying hold pressure and occasional resets.
        for (int seg = 0; seg < 20; seg++) begin
            int holdPct;
            int validPct;
            holdPct  = int'($urandom_range(0, 70));
            validPct = int'($urandom_range(30, 95));
            for (int i = 0; i < 100; i++) begin
                logic          m;
                logic [CW-1:0] c;
                m = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 99) < 30) begin
                    c = ($urandom_range(0, 1) == 0) ? 4'd9 : 4'd10;
                end else begin
                    c = 4'($urandom_range(0, 15));
                end
                applyStimulus(1'($urandom_range(0, 99) < validPct), m, c,
                              8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                              2'($urandom_range(0, 3)),
                              1'($urandom_range(0, 99) < holdPct));
                if ($urandom_range(0, 299) == 0) begin
                    RESET = 1'b0;
                    nextCycle();
                    RESET = 1'b1;
                end else begin
                    nextCycle();
                end
            end
        end

        applyIdle(1'b0);
        repeat (30) nextCycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
